// File: rtl/fpga_ahb_regfile.sv
// AHB-lite register slave: ID, scratch, control, status and a masked rising-edge interrupt bank.
// Latency: HREADY pulses for one cycle, WAIT_STATES+1 cycles after HSEL is first sampled.
// Backpressure: one request at a time; HSEL must be seen low after HREADY before the next is taken.
module fpga_ahb_regfile #(
    parameter logic [31:0] ID_VALUE    = 32'h4831_0D03,
    parameter int          WAIT_STATES = 2,
    parameter int          IRQ_W       = 8,
    parameter logic [19:0] BASE_ADDR   = 20'h00000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fpga_HSEL,
    input  logic             fpga_HWRITE,
    input  logic [19:0]      fpga_HADDR,
    input  logic [31:0]      fpga_HWDATA,
    output logic [31:0]      fpga_HRDATA,
    output logic             fpga_HREADY,
    output logic [31:0]      ctrl_o,
    input  logic [31:0]      status_i,
    input  logic [IRQ_W-1:0] irq_src_i,
    output logic             interrupt
);

    localparam logic [5:0] OFF_ID      = 6'h00;
    localparam logic [5:0] OFF_SCRATCH = 6'h01;
    localparam logic [5:0] OFF_CTRL    = 6'h02;
    localparam logic [5:0] OFF_STATUS  = 6'h03;
    localparam logic [5:0] OFF_STAT    = 6'h04;
    localparam logic [5:0] OFF_MASK    = 6'h05;
    localparam logic [5:0] OFF_PEND    = 6'h06;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK, S_HOLD} state_t;

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             wr_q, wr_d;
    logic [17:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [31:0]      hrdata_q, hrdata_d;
    logic             hready_q, hready_d;
    logic [31:0]      scratch_q, scratch_d;
    logic [31:0]      ctrl_q, ctrl_d;
    logic [IRQ_W-1:0] irq_stat_q, irq_stat_d;
    logic [IRQ_W-1:0] irq_mask_q, irq_mask_d;
    logic [IRQ_W-1:0] irq_src_q, irq_src_d;
    logic             interrupt_q, interrupt_d;

    logic [17:0]      acc_addr;
    logic [31:0]      rd_val;
    logic             wr_hit;
    logic             go_ack;
    logic [IRQ_W-1:0] irq_clr;
    logic [1:0]       unused_haddr;

    assign unused_haddr = fpga_HADDR[1:0];

    function automatic logic [31:0] ext_irq(input logic [IRQ_W-1:0] v);
        ext_irq            = '0;
        ext_irq[IRQ_W-1:0] = v;
    endfunction

    // With zero wait states the read is resolved straight from the live bus in IDLE.
    always_comb begin
        acc_addr = (state_q == S_IDLE) ? fpga_HADDR[19:2] : addr_q;
        rd_val   = '0;
        if (acc_addr[17:6] == BASE_ADDR[19:8]) begin
            case (acc_addr[5:0])
                OFF_ID:      rd_val = ID_VALUE;
                OFF_SCRATCH: rd_val = scratch_q;
                OFF_CTRL:    rd_val = ctrl_q;
                OFF_STATUS:  rd_val = status_i;
                OFF_STAT:    rd_val = ext_irq(irq_stat_q);
                OFF_MASK:    rd_val = ext_irq(irq_mask_q);
                OFF_PEND:    rd_val = ext_irq(irq_stat_q & irq_mask_q);
                default:     rd_val = '0;
            endcase
        end
    end

    always_comb begin
        wr_hit     = (state_q == S_ACK) && wr_q && (addr_q[17:6] == BASE_ADDR[19:8]);
        scratch_d  = scratch_q;
        ctrl_d     = ctrl_q;
        irq_mask_d = irq_mask_q;
        irq_clr    = '0;
        if (wr_hit) begin
            case (addr_q[5:0])
                OFF_SCRATCH: scratch_d  = wdata_q;
                OFF_CTRL:    ctrl_d     = wdata_q;
                OFF_STAT:    irq_clr    = wdata_q[IRQ_W-1:0];
                OFF_MASK:    irq_mask_d = wdata_q[IRQ_W-1:0];
                default:     ;
            endcase
        end
        irq_src_d   = irq_src_i;
        // A fresh edge outranks a simultaneous W1C on the same bit.
        irq_stat_d  = (irq_stat_q & ~irq_clr) | (irq_src_i & ~irq_src_q);
        interrupt_d = |(irq_stat_q & irq_mask_q);
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wr_d     = wr_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        hrdata_d = hrdata_q;
        hready_d = 1'b0;
        go_ack   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (fpga_HSEL) begin
                    wr_d    = fpga_HWRITE;
                    addr_d  = fpga_HADDR[19:2];
                    wdata_d = fpga_HWDATA;
                    cnt_d   = 4'(WAIT_STATES);
                    if (WAIT_STATES == 0) go_ack = 1'b1;
                    else                  state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!fpga_HSEL) begin
                    state_d = S_IDLE;
                end else if (cnt_q == 4'd1) begin
                    // The bridge settles HWRITE later than HSEL, so take its final value here.
                    wr_d   = fpga_HWRITE;
                    go_ack = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_ACK:   state_d = S_HOLD;
            S_HOLD:  if (!fpga_HSEL) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (go_ack) begin
            state_d  = S_ACK;
            hready_d = 1'b1;
            if (!fpga_HWRITE) hrdata_d = rd_val;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            hrdata_q    <= '0;
            hready_q    <= 1'b0;
            scratch_q   <= '0;
            ctrl_q      <= '0;
            irq_stat_q  <= '0;
            irq_mask_q  <= '0;
            irq_src_q   <= '0;
            interrupt_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            hrdata_q    <= hrdata_d;
            hready_q    <= hready_d;
            scratch_q   <= scratch_d;
            ctrl_q      <= ctrl_d;
            irq_stat_q  <= irq_stat_d;
            irq_mask_q  <= irq_mask_d;
            irq_src_q   <= irq_src_d;
            interrupt_q <= interrupt_d;
        end
    end

    assign fpga_HRDATA = hrdata_q;
    assign fpga_HREADY = hready_q;
    assign ctrl_o      = ctrl_q;
    assign interrupt   = interrupt_q;

endmodule

// File: tb/tb_fpga_ahb_regfile.sv
// Directed bench for fpga_ahb_regfile with default parameters (WAIT_STATES=2, IRQ_W=8).
module tb_fpga_ahb_regfile;

    logic        clk;
    logic        rst_n;
    logic        fpga_HSEL;
    logic        fpga_HWRITE;
    logic [19:0] fpga_HADDR;
    logic [31:0] fpga_HWDATA;
    logic [31:0] fpga_HRDATA;
    logic        fpga_HREADY;
    logic [31:0] ctrl_o;
    logic [31:0] status_i;
    logic [7:0]  irq_src_i;
    logic        interrupt;

    int          n_checks;
    int          n_fail;
    logic [31:0] rd;
    int          edges;
    int          pulses;

    fpga_ahb_regfile dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fpga_HSEL   (fpga_HSEL),
        .fpga_HWRITE (fpga_HWRITE),
        .fpga_HADDR  (fpga_HADDR),
        .fpga_HWDATA (fpga_HWDATA),
        .fpga_HRDATA (fpga_HRDATA),
        .fpga_HREADY (fpga_HREADY),
        .ctrl_o      (ctrl_o),
        .status_i    (status_i),
        .irq_src_i   (irq_src_i),
        .interrupt   (interrupt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req_start(input logic w, input logic [19:0] a, input logic [31:0] d);
        fpga_HSEL   = 1'b1;
        fpga_HWRITE = w;
        fpga_HADDR  = a;
        fpga_HWDATA = d;
    endtask

    task automatic req_wait(output logic [31:0] rdata, output int n);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            n++;
            if (fpga_HREADY) break;
        end
        if (!fpga_HREADY) check("hready_timeout", 32'd0, 32'd1);
        rdata = fpga_HRDATA;
    endtask

    task automatic req_end();
        fpga_HSEL   = 1'b0;
        fpga_HWRITE = 1'b0;
        tick();
        tick();
    endtask

    task automatic xfer(input logic w, input logic [19:0] a, input logic [31:0] d,
                        output logic [31:0] rdata, output int n);
        req_start(w, a, d);
        req_wait(rdata, n);
        req_end();
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        rst_n       = 1'b0;
        fpga_HSEL   = 1'b0;
        fpga_HWRITE = 1'b0;
        fpga_HADDR  = '0;
        fpga_HWDATA = '0;
        status_i    = 32'h1234_5678;
        irq_src_i   = '0;
        repeat (3) tick();
        check("rst_hrdata", fpga_HRDATA, 32'h0);
        check("rst_hready", fpga_HREADY, 32'h0);
        check("rst_ctrl", ctrl_o, 32'h0);
        check("rst_irq", interrupt, 32'h0);
        rst_n = 1'b1;
        tick();

        // ID read: HREADY on the third edge counting the capture edge
        xfer(1'b0, 20'h00000, 32'h0, rd, edges);
        check("id_latency", edges, 32'd3);
        check("id_data", rd, 32'h4831_0D03);

        xfer(1'b1, 20'h00004, 32'hA5C3_0F1E, rd, edges);
        check("scr_wr_latency", edges, 32'd3);
        xfer(1'b0, 20'h00004, 32'h0, rd, edges);
        check("scr_rd", rd, 32'hA5C3_0F1E);
        check("ctrl_untouched", ctrl_o, 32'h0);

        // CTRL write: ctrl_o must change exactly at the edge ending ACK
        req_start(1'b1, 20'h00008, 32'h0000_0013);
        req_wait(rd, edges);
        check("ctrl_before_commit", ctrl_o, 32'h0);
        fpga_HSEL = 1'b0;
        tick();
        check("ctrl_after_ack", ctrl_o, 32'h0000_0013);
        tick();
        xfer(1'b0, 20'h0000C, 32'h0, rd, edges);
        check("status_rd", rd, 32'h1234_5678);
        xfer(1'b0, 20'h00008, 32'h0, rd, edges);
        check("ctrl_rd", rd, 32'h0000_0013);

        // IRQ bank; upper mask bits beyond IRQ_W are dropped
        xfer(1'b1, 20'h00014, 32'hFFFF_FF01, rd, edges);
        xfer(1'b0, 20'h00014, 32'h0, rd, edges);
        check("mask_rd", rd, 32'h0000_0001);
        check("irq_idle", interrupt, 32'h0);
        irq_src_i = 8'h01;
        tick();
        tick();
        check("irq_asserted", interrupt, 32'h1);
        irq_src_i = 8'h00;
        xfer(1'b0, 20'h00010, 32'h0, rd, edges);
        check("stat_rd", rd, 32'h0000_0001);
        xfer(1'b0, 20'h00018, 32'h0, rd, edges);
        check("pend_rd", rd, 32'h0000_0001);
        req_start(1'b1, 20'h00010, 32'h0000_0001);
        req_wait(rd, edges);
        irq_src_i = 8'h01;
        req_end();
        irq_src_i = 8'h00;
        xfer(1'b0, 20'h00010, 32'h0, rd, edges);
        check("stat_set_wins", rd, 32'h0000_0001);
        check("irq_held", interrupt, 32'h1);
        xfer(1'b1, 20'h00010, 32'h0000_0001, rd, edges);
        check("irq_cleared", interrupt, 32'h0);
        xfer(1'b0, 20'h00010, 32'h0, rd, edges);
        check("stat_w1c", rd, 32'h0);

        // Unmapped and base-mismatch accesses complete but change nothing
        xfer(1'b1, 20'h00040, 32'hDEAD_BEEF, rd, edges);
        check("unmap_wr_latency", edges, 32'd3);
        xfer(1'b1, 20'h10100, 32'hDEAD_BEEF, rd, edges);
        check("base_wr_latency", edges, 32'd3);
        xfer(1'b1, 20'h10104, 32'hDEAD_BEEF, rd, edges);
        xfer(1'b1, 20'h10108, 32'hDEAD_BEEF, rd, edges);
        xfer(1'b1, 20'h00000, 32'hDEAD_BEEF, rd, edges);
        xfer(1'b0, 20'h00040, 32'h0, rd, edges);
        check("unmap_rd", rd, 32'h0);
        xfer(1'b0, 20'h10100, 32'h0, rd, edges);
        check("base_rd", rd, 32'h0);
        xfer(1'b0, 20'h00004, 32'h0, rd, edges);
        check("scr_kept", rd, 32'hA5C3_0F1E);
        check("ctrl_kept", ctrl_o, 32'h0000_0013);
        xfer(1'b0, 20'h00000, 32'h0, rd, edges);
        check("id_ro", rd, 32'h4831_0D03);

        // HSEL held long after HREADY: no second pulse
        req_start(1'b0, 20'h00000, 32'h0);
        req_wait(rd, edges);
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (fpga_HREADY) pulses++;
        end
        req_end();
        check("hold_single_pulse", pulses, 32'd0);

        // HSEL dropped in WAIT: no HREADY, no write
        req_start(1'b1, 20'h00004, 32'h1111_1111);
        tick();
        fpga_HSEL = 1'b0;
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (fpga_HREADY) pulses++;
        end
        check("abort_no_ready", pulses, 32'd0);
        xfer(1'b0, 20'h00004, 32'h0, rd, edges);
        check("abort_no_write", rd, 32'hA5C3_0F1E);

        // HWRITE rises after HSEL; the late value decides the direction
        req_start(1'b0, 20'h00004, 32'h5A5A_5A5A);
        tick();
        fpga_HWRITE = 1'b1;
        req_wait(rd, edges);
        req_end();
        xfer(1'b0, 20'h00004, 32'h0, rd, edges);
        check("late_hwrite", rd, 32'h5A5A_5A5A);

        // Reset during WAIT with interrupt and HRDATA non-zero
        irq_src_i = 8'h01;
        tick();
        tick();
        irq_src_i = 8'h00;
        check("irq_pre_reset", interrupt, 32'h1);
        xfer(1'b0, 20'h00008, 32'h0, rd, edges);
        req_start(1'b1, 20'h00008, 32'h0000_FFFF);
        tick();
        rst_n = 1'b0;
        #1;
        check("arst_hrdata", fpga_HRDATA, 32'h0);
        check("arst_hready", fpga_HREADY, 32'h0);
        check("arst_ctrl", ctrl_o, 32'h0);
        check("arst_irq", interrupt, 32'h0);
        fpga_HSEL   = 1'b0;
        fpga_HWRITE = 1'b0;
        tick();
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (fpga_HREADY) pulses++;
        end
        check("arst_no_ready", pulses, 32'd0);
        check("arst_ctrl_after", ctrl_o, 32'h0);
        xfer(1'b0, 20'h00004, 32'h0, rd, edges);
        check("arst_scratch", rd, 32'h0);
        xfer(1'b0, 20'h00014, 32'h0, rd, edges);
        check("arst_mask", rd, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
